// File: rtl/wallace_mul.sv
// wallace_mul: 16x16 unsigned Wallace-tree multiplier with a registered 32-bit product
module wallace_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] number1,
  input  logic [15:0] number0,
  output logic [31:0] q
);
  localparam int CNT [7] = '{16, 11, 8, 6, 4, 3, 2};
  logic [31:0] t [7][16];
  logic [31:0] q_d;
  logic [31:0] q_q;
  // Partial products reduced level by level with 3:2 compressors; each level keeps leftover rows, and columns with only two live bits degenerate to half adders
  always_comb begin
    t = '{default: '0};
    for (int i = 0; i < 16; i++) t[0][i] = {16'b0, number1 & {16{number0[i]}}} << i;
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < CNT[s] / 3; j++) begin
        t[s+1][2*j]   = t[s][3*j] ^ t[s][3*j+1] ^ t[s][3*j+2];
        t[s+1][2*j+1] = ((t[s][3*j] & t[s][3*j+1]) | (t[s][3*j] & t[s][3*j+2]) | (t[s][3*j+1] & t[s][3*j+2])) << 1;
      end
      for (int j = 3 * (CNT[s] / 3); j < CNT[s]; j++) t[s+1][j - CNT[s] / 3] = t[s][j];
    end
    q_d = t[6][0] + t[6][1];
  end
  // Output register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: tb/tb_wallace_mul.sv
// tb_wallace_mul: directed vector table plus reset/timing sequences and a random sweep
module tb_wallace_mul;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] number1 = '0;
  logic [15:0] number0 = '0;
  logic [31:0] q;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  wallace_mul dut (.clk(clk), .rst_n(rst_n), .number1(number1), .number0(number0), .q(q));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    rst_n = r;
    number1 = a;
    number0 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v [16];
    logic [15:0] ra, rb;
    logic r;
    v[0]  = '{1'b0, 16'd111,   16'd58,    32'd0};
    v[1]  = '{1'b0, 16'd111,   16'd58,    32'd0};
    v[2]  = '{1'b1, 16'd111,   16'd0,     32'd0};
    v[3]  = '{1'b1, 16'd111,   16'd58,    32'h0000_1926};
    v[4]  = '{1'b1, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001};
    v[5]  = '{1'b1, 16'h8000,  16'h0002,  32'h0001_0000};
    v[6]  = '{1'b1, 16'h0002,  16'h8000,  32'h0001_0000};
    v[7]  = '{1'b1, 16'd3,     16'd5,     32'd15};
    v[8]  = '{1'b1, 16'd1000,  16'd1000,  32'd1000000};
    v[9]  = '{1'b1, 16'd0,     16'hFFFF,  32'd0};
    v[10] = '{1'b1, 16'hFFFF,  16'd0,     32'd0};
    v[11] = '{1'b1, 16'd1,     16'd1,     32'd1};
    v[12] = '{1'b1, 16'hFFFF,  16'd1,     32'h0000_FFFF};
    v[13] = '{1'b1, 16'h00FF,  16'h0101,  32'h0000_FFFF};
    v[14] = '{1'b0, 16'hFFFF,  16'hFFFF,  32'd0};
    v[15] = '{1'b1, 16'h1234,  16'h0001,  32'h0000_1234};
    for (int i = 0; i < 16; i++) begin
      step(v[i].rst_n, v[i].a, v[i].b);
      check($sformatf("vec%0d", i), q, v[i].exp);
    end
    step(1'b1, 16'd7, 16'd9);
    check("seq_load", q, 32'd63);
    #2;
    number1 = 16'd100;
    number0 = 16'd100;
    rst_n = 1'b0;
    #1;
    check("seq_hold_between_edges", q, 32'd63);
    @(posedge clk);
    #1;
    check("seq_sync_reset", q, 32'd0);
    step(1'b1, 16'd100, 16'd100);
    check("seq_first_after_reset", q, 32'd10000);
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      r = !(i >= 5000 && i < 5003);
      step(r, ra, rb);
      check("random", q, r ? 32'(ra) * 32'(rb) : 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wallace_mul.md
WALLACE_MUL -- requirements
Module: wallace_mul

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 number1  input  16  multiplicand, unsigned.
REQ-005 number0  input  16  multiplier, unsigned.
REQ-006 q  output  32  registered unsigned product number1*number0.

Function
REQ-007 The block SHALL compute the full 32-bit unsigned product of number1 and number0, with no truncation, rounding or overflow.
REQ-008 Partial products SHALL be 16 rows of AND-gated terms: row i = number1 & {16{number0[i]}}, shifted left by i.
REQ-009 Partial products SHALL be reduced by a Wallace tree of full adders (3:2) and half adders (2:2) to two rows, then summed by one 32-bit carry-propagate adder.
REQ-010 The reduction and final adder SHALL be purely combinational between the input ports and the output register; no pipeline stages inside the tree.
REQ-011 q SHALL be registered: at each rising clk edge with rst_n=1, q loads the product of the number1/number0 values present at that edge.
REQ-012 Latency SHALL be 1 clock: a product appears on q after the first rising edge that samples the operands, and holds until the next edge.
REQ-013 Operands SHALL be accepted every cycle; there is no handshake, valid or busy signal, and throughput is one product per clock.
REQ-014 Operand changes between clock edges SHALL NOT affect q until the next rising edge.
REQ-015 Boundary: a zero operand SHALL give q=0; 0xFFFF*0xFFFF SHALL give 0xFFFE0001, and the MSB carry SHALL be kept in q[31].
REQ-016 The product SHALL be independent of operand order: number1*number0 = number0*number1.

Reset
REQ-017 While rst_n=0 at a rising clk edge, q SHALL be set to 32'h0000_0000, whatever the operand values.
REQ-018 Reset SHALL be synchronous only; asserting rst_n low between edges SHALL NOT change q before the next rising edge.
REQ-019 On the first rising edge with rst_n=1, q SHALL load the product of the operands present at that edge.
REQ-020 Asserting rst_n mid-stream SHALL discard the in-flight product; q=0 until the first edge after deassertion.

Verification
REQ-021 rst_n=0 for 2 cycles with number1=111, number0=58 -> q=0 throughout.
REQ-022 rst_n=1, number1=111, then number0 changes 0->58 -> q=0 after the first edge, then q=6438 (0x0000_1926) one edge after number0=58.
REQ-023 number1=0xFFFF, number0=0xFFFF -> q=0xFFFE_0001 after one edge.
REQ-024 number1=0x8000, number0=0x0002 -> q=0x0001_0000; swapping the operands gives the same result.
REQ-025 Back-to-back operands 3*5, 1000*1000, 0*0xFFFF on consecutive cycles -> q=15, 1000000, 0 on consecutive edges.
REQ-026 Random unsigned operand pairs (at least 10000) against a reference multiply, with rst_n pulsed low mid-stream -> every q matches the product, and q=0 on each edge while rst_n=0.
